// File: rtl/pipe_adder_pkg.sv
// ----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared ALU definitions: op-mode encoding for the add/subtract unit and the
// bit positions of the ALU flag register that consumes carry/overflow/zero.
// ----------------------------------------------------------------------------
package pipe_adder_pkg;

    // Op-mode encoding on the 'sub' input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Flag register bit indices
    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/pipe_adder_slice.sv
// ----------------------------------------------------------------------------
// pipe_adder_slice
// Combinational CHUNK-bit adder used for one pipeline stage.
//   a, b   : CHUNK-bit operand slices (b already inverted for subtract)
//   cin    : carry into this slice
//   s      : CHUNK-bit sum slice
//   cout   : carry out of this slice
//   s_msb  : top bit of s, used for signed overflow on the last slice
// ----------------------------------------------------------------------------
module pipe_adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             s_msb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s_msb     = s[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// ----------------------------------------------------------------------------
// pipe_adder
// Pipelined WIDTH-bit add/subtract unit, CHUNK bits per stage, valid/ready
// on both sides. Latency STAGES cycles, one operation per cycle unstalled.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (num_1, num_2, c_in, sub)
//   out_valid/out_ready : result handshake (sum, carry, overflow, zero)
//   carry               : carry out of MSB; in subtract mode 1 = no borrow
//   overflow            : two's-complement signed overflow
//   zero                : sum == 0
// ----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_1,
    input  logic [WIDTH-1:0] num_2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    logic                         adv;
    logic                         fire;
    logic [WIDTH-1:0]             b_eff;
    logic                         c_eff;

    // Stage k registers: a_q holds finished sum slices 0..k and the untouched
    // upper slices of operand A; b_q holds the (possibly inverted) operand B.
    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_nxt;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_nxt;
    logic [STAGES-1:0]            c_q, c_nxt;
    logic                         ovf_q, ovf_nxt;
    logic                         zero_q, zero_nxt;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || rst;
    assign fire     = in_valid && adv;

    // Subtract is A + ~B + ~borrow_in.
    assign b_eff = (sub == OP_SUB) ? ~num_2 : num_2;
    assign c_eff = (sub == OP_SUB) ? ~c_in  : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_prev, b_prev, merged;
        logic             c_prev;
        logic [CHUNK-1:0] s;
        logic             s_msb;

        if (k == 0) begin : g_first
            assign a_prev = num_1;
            assign b_prev = b_eff;
            assign c_prev = c_eff;
        end else begin : g_next
            assign a_prev = a_q[k-1];
            assign b_prev = b_q[k-1];
            assign c_prev = c_q[k-1];
        end

        pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a     (a_prev[k*CHUNK +: CHUNK]),
            .b     (b_prev[k*CHUNK +: CHUNK]),
            .cin   (c_prev),
            .s     (s),
            .cout  (c_nxt[k]),
            .s_msb (s_msb)
        );

        always_comb begin
            merged                    = a_prev;
            merged[k*CHUNK +: CHUNK]  = s;
        end

        assign a_nxt[k] = merged;
        assign b_nxt[k] = b_prev;

        // Upper slice of a_prev/b_prev is still the raw operand here.
        if (k == STAGES-1) begin : g_last
            assign ovf_nxt  = (a_prev[WIDTH-1] == b_prev[WIDTH-1]) &&
                              (s_msb != a_prev[WIDTH-1]);
            assign zero_nxt = (merged == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (adv) begin
            vld_pipe[0] <= fire;
            for (int k = 1; k < STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            c_q    <= c_nxt;
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = a_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_pipe_adder
// Directed vectors for pipe_adder (WIDTH=32, CHUNK=8). The driver pushes the
// expected result of every accepted operation into a scoreboard queue; the
// monitor pops and compares whenever a result transfers out.
// ----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = WIDTH / CHUNK;
    localparam int NVEC   = 23;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] num_1 = '0;
    logic [WIDTH-1:0] num_2 = '0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_1     (num_1),
        .num_2     (num_2),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a, b;
        logic             cin, sb;
        logic [WIDTH-1:0] s;
        logic             c, v, z;
    } vec_t;

    typedef struct {
        int id;
        int acc;
        bit lat;
    } exp_t;

    vec_t vt [NVEC];
    exp_t scb [$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    task automatic setv(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sb, input logic [31:0] s,
                        input logic c, input logic v, input logic z);
        vt[i].a = a; vt[i].b = b; vt[i].cin = cin; vt[i].sb = sb;
        vt[i].s = s; vt[i].c = c; vt[i].v = v; vt[i].z = z;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, between driver updates.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst && out_valid && out_ready) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum=%h with no operation outstanding", sum);
            end else begin
                e = scb.pop_front();
                check($sformatf("result[%0d] {c,v,z,sum}", e.id),
                      {29'd0, carry, overflow, zero, sum},
                      {29'd0, vt[e.id].c, vt[e.id].v, vt[e.id].z, vt[e.id].s});
                if (e.lat)
                    check($sformatf("latency[%0d]", e.id), 64'(ncyc - e.acc), 64'(STAGES));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int id, input bit lat);
        int n;
        num_1    = vt[id].a;
        num_2    = vt[id].b;
        c_in     = vt[id].cin;
        sub      = vt[id].sb;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d]: in_ready stayed 0, expected 1 within 50 cycles", id);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            scb.push_back('{id, ncyc, lat});
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        setv( 0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1);
        setv( 1, 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0);
        setv( 2, 32'h00FFFFFF, 32'h00000001, 0, 0, 32'h01000000, 0, 0, 0);
        setv( 3, 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
        setv( 4, 32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0, 0);
        setv( 5, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0);
        setv( 6, 32'h0000FFFF, 32'h00000000, 1, 0, 32'h00010000, 0, 0, 0);
        setv( 7, 32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 1, 0, 1);
        setv( 8, 32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0, 0);
        setv( 9, 32'h00000010, 32'h00000001, 1, 1, 32'h0000000E, 1, 0, 0);
        setv(10, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1);
        setv(11, 32'h12345678, 32'h87654321, 0, 0, 32'h99999999, 0, 0, 0);
        setv(12, 32'h11111111, 32'h22222222, 0, 0, 32'h33333333, 0, 0, 0);
        setv(13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        setv(14, 32'h00000000, 32'h00000000, 1, 1, 32'hFFFFFFFF, 0, 0, 0);
        setv(15, 32'h40000000, 32'h40000000, 0, 0, 32'h80000000, 0, 1, 0);
        setv(16, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 1, 32'h80000000, 0, 1, 0);
        setv(17, 32'h0000FF00, 32'h00000100, 0, 0, 32'h00010000, 0, 0, 0);
        setv(18, 32'h00000001, 32'h00000001, 0, 0, 32'h00000002, 0, 0, 0);
        setv(19, 32'h00000003, 32'h00000003, 0, 0, 32'h00000006, 0, 0, 0);
        setv(20, 32'h0000000F, 32'h00000001, 0, 0, 32'h00000010, 0, 0, 0);
        setv(21, 32'h00000007, 32'h00000008, 0, 0, 32'h0000000F, 0, 0, 0);
        setv(22, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst sum",       64'(sum),       64'd0);
        check("rst carry",     64'(carry),     64'd0);
        check("rst overflow",  64'(overflow),  64'd0);
        check("rst zero",      64'(zero),      64'd0);
        check("rst in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single add / sub with wrap, carry, overflow
        send(0, 1); idle(6);
        send(1, 1); idle(6);

        // Cross-slice ripple followed immediately by an unrelated operation
        send(2, 1); send(3, 1); idle(6);

        // Eight back-to-back operations
        for (int i = 4; i <= 11; i++) send(i, 1);
        idle(8);

        // Fill the pipe against a stalled output, hold, then release
        out_ready = 1'b0;
        for (int i = 12; i <= 15; i++) send(i, 0);
        num_1 = vt[16].a; num_2 = vt[16].b; c_in = vt[16].cin; sub = vt[16].sb;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready",  64'(in_ready),  64'd0);
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall held {c,v,z,sum}", {29'd0, carry, overflow, zero, sum},
                  {29'd0, vt[12].c, vt[12].v, vt[12].z, vt[12].s});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16, 1);
        send(17, 1);
        idle(10);

        // Reset with three operations in flight
        send(18, 1); send(19, 1); send(20, 1);
        rst = 1'b1;
        num_1 = vt[22].a; num_2 = vt[22].b; c_in = vt[22].cin; sub = vt[22].sb;
        in_valid = 1'b1;
        scb.delete();
        @(negedge clk);
        check("in_ready during rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-rst out_valid", 64'(out_valid), 64'd0);
        check("post-rst in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        idle(6);
        send(21, 1);
        idle(6);

        check("scoreboard drained", 64'(scb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit. It is the next generation of our fixed-width ripple adder.
- A WIDTH-bit operation is split into CHUNK-bit slices, one slice per pipeline stage. The carry is registered between stages, so fmax is set by a CHUNK-bit adder regardless of WIDTH.
- It sits in the ALU datapath behind a valid/ready handshake. Throughput is one operation per cycle when the output is not stalled.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage.
- STAGES (localparam, not overridable), WIDTH/CHUNK, number of pipeline stages and cycles of latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present on num_1/num_2/c_in/sub.
- in_ready  out  1  unit accepts the operand set this cycle.
- num_1  in  WIDTH  first operand.
- num_2  in  WIDTH  second operand.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- carry  out  1  carry out of the MSB; in sub mode, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Arithmetic:
  - sub=0: {carry,sum} = num_1 + num_2 + c_in.
  - sub=1: {carry,sum} = num_1 + ~num_2 + ~c_in, i.e. num_1 - num_2 - c_in.
  - Inversion of num_2 and c_in happens at stage 0 capture.
  - overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is the possibly-inverted num_2.
  - zero is computed from the full WIDTH result in the final stage.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv. This is combinational from out_valid/out_ready; it is not a function of in_valid.
  - When adv=0 every stage register, including the output registers, holds its value.
- Pipeline and latency:
  - Stage k (0..STAGES-1) adds slice k using the carry registered by stage k-1; stage 0 uses the effective c_in.
  - Not-yet-added upper slices are skewed forward through registers; finished lower slices are carried along.
  - Each stage has a valid bit. Bubbles (in_valid=0 with adv=1) propagate as valid=0.
  - Latency: an operation accepted on edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages with the result visible the cycle after the last add.
  - Back-to-back accepts produce back-to-back results.
- Output stability: while out_valid=1 && out_ready=0, sum/carry/overflow/zero are stable.
- Reset:
  - While rst=1, all stage valid bits clear and all data registers clear.
  - out_valid=0, sum=0, carry=0, overflow=0, zero=0.
  - in_ready=1 during reset; any accept in that cycle is discarded.
  - Reset mid-operation drops all in-flight operations; no partial results ever emerge.
- Boundary conditions:
  - Carry out of slice k must reach slice k+1 of the same operation only, never a neighbouring operation.
  - STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.
  - Simultaneous accept and emit while full is legal and loses nothing.

Decomposition:
- Shared ALU package holds the op-mode encoding constants (OP_ADD=1'b0, OP_SUB=1'b1) and the flag-bit index constants reused by the ALU flag register.
- One sub-module: pipe_adder_slice, a combinational CHUNK-bit adder (a, b, cin -> s, cout, plus the MSB sum needed for overflow).
- A generate loop instantiates STAGES slices with their stage registers.

Test Plan (WIDTH=32, CHUNK=8, STAGES=4):
1. Add 0xFFFFFFFF + 0x00000001, c_in=0, out_ready=1 -> after 4 cycles sum=0x00000000, carry=1, zero=1, overflow=0.
2. Sub 0x80000000 - 0x00000001, c_in=0 -> sum=0x7FFFFFFF, carry=1, overflow=1, zero=0.
3. Cross-slice ripple: add 0x00FFFFFF + 0x00000001 -> sum=0x01000000, carry=0. Then, back-to-back, 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1. No carry leaks between the two operations.
4. Eight back-to-back accepts with out_ready=1 -> eight results on consecutive cycles, in order, starting 4 cycles after the first accept.
5. Pipe full, out_ready=0 for 3 cycles -> in_ready=0 for those cycles, outputs held constant; after release all results arrive in order with no loss or duplication.
6. rst=1 for one cycle with 3 operations in flight -> next cycle out_valid=0, in_ready=1; no stale result ever appears; a fresh operation then completes with latency 4.
